// File: rtl/key_buffer_pkg.sv
// Shared definitions for the bcrypt password key store: sizes, state encoding
// and the storage element types.
package key_buffer_pkg;

  localparam int unsigned MAX_KEY_BYTES = 72;
  localparam logic [6:0]  KEY_LEN_MAX   = 7'd72;
  localparam logic [6:0]  KEY_LAST      = 7'd71;

  typedef logic [7:0]      byte_t;
  typedef logic [7:0][7:0] key_word_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_TERM   = 3'd2,
    ST_EXPAND = 3'd3,
    ST_READY  = 3'd4
  } state_e;

endpackage : key_buffer_pkg

// File: rtl/key_buffer_if.sv
// Loader/consumer interface of the key store: password byte stream in,
// eight-byte windowed read of the expanded key stream out.
interface key_buffer_if;
  import key_buffer_pkg::*;

  logic      load_start;
  logic      byte_valid;
  byte_t     byte_data;
  logic      byte_ready;
  logic      load_end;
  logic [6:0] key_addr;
  key_word_t key_data;
  logic [6:0] key_len;
  logic      key_ready;
  logic      overflow;

  modport slave (
    input  load_start, byte_valid, byte_data, load_end, key_addr,
    output byte_ready, key_data, key_len, key_ready, overflow
  );

  modport master (
    output load_start, byte_valid, byte_data, load_end, key_addr,
    input  byte_ready, key_data, key_len, key_ready, overflow
  );

endinterface : key_buffer_if

// File: rtl/key_buffer.sv
// bcrypt password key store: collects up to 72 password bytes, appends the NUL
// terminator and precomputes the 72-byte cyclic key stream for EksBlowfish.
module key_buffer
  import key_buffer_pkg::*;
(
  input logic         clk,
  input logic         reset,
  key_buffer_if.slave kb
);

  state_e     state_q, state_d;
  logic [6:0] wr_cnt_q, wr_cnt_d;
  logic [6:0] key_len_q, key_len_d;
  logic [6:0] j_q, j_d;
  logic [6:0] s_q, s_d;
  logic       overflow_q, overflow_d;
  logic       byte_ready_q, byte_ready_d;
  logic       key_ready_q, key_ready_d;

  byte_t      pw_q  [MAX_KEY_BYTES];
  byte_t      exp_q [MAX_KEY_BYTES];

  logic       byte_acc_s;
  logic       cnt_full_s;
  logic       pw_we_s;
  byte_t      pw_wdata_s;
  logic       exp_we_s;
  key_word_t  key_data_s;

  // Window offsets never exceed 127 + 7 = 134, so one subtraction wraps them.
  function automatic logic [6:0] wrap_idx(input logic [6:0] addr, input logic [2:0] off);
    logic [7:0] sum;
    sum = {1'b0, addr} + {5'b00000, off};
    if (sum >= 8'd72) begin
      return 7'(sum - 8'd72);
    end else begin
      return 7'(sum);
    end
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load_start overrides everything, including EXPAND and READY
  always_comb begin
    state_d = state_q;
    if (kb.load_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_LOAD:   state_d = kb.load_end ? ST_TERM : ST_LOAD;
        ST_TERM:   state_d = ST_EXPAND;
        ST_EXPAND: state_d = (j_q == KEY_LAST) ? ST_READY : ST_EXPAND;
        ST_READY:  state_d = ST_READY;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next-state: write counter, terminator, key length and expansion walk
  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    key_len_d  = key_len_q;
    overflow_d = overflow_q;
    j_d        = j_q;
    s_d        = s_q;
    pw_we_s    = 1'b0;
    pw_wdata_s = 8'h00;
    exp_we_s   = 1'b0;
    byte_acc_s = kb.byte_valid && byte_ready_q;
    cnt_full_s = (wr_cnt_q == KEY_LEN_MAX);
    if (kb.load_start) begin
      wr_cnt_d   = 7'd0;
      key_len_d  = 7'd0;
      overflow_d = 1'b0;
      j_d        = 7'd0;
      s_d        = 7'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (byte_acc_s && !cnt_full_s) begin
            pw_we_s    = 1'b1;
            pw_wdata_s = kb.byte_data;
            wr_cnt_d   = wr_cnt_q + 7'd1;
          end else if (byte_acc_s) begin
            overflow_d = 1'b1;
          end else begin
            wr_cnt_d   = wr_cnt_q;
          end
        end
        ST_TERM: begin
          j_d = 7'd0;
          s_d = 7'd0;
          if (!cnt_full_s) begin
            pw_we_s    = 1'b1;
            pw_wdata_s = 8'h00;
            key_len_d  = wr_cnt_q + 7'd1;
          end else begin
            key_len_d  = KEY_LEN_MAX;
          end
        end
        ST_EXPAND: begin
          exp_we_s = 1'b1;
          j_d      = j_q + 7'd1;
          // Cyclic source index without a divider: compare against key_len
          if ((s_q + 7'd1) == key_len_q) begin
            s_d = 7'd0;
          end else begin
            s_d = s_q + 7'd1;
          end
        end
        default: begin
          wr_cnt_d = wr_cnt_q;
        end
      endcase
    end
  end

  // Output flag next-state; key_ready trails READY entry by one edge
  always_comb begin
    byte_ready_d = (state_d == ST_LOAD);
    key_ready_d  = !kb.load_start && (state_q == ST_READY);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt_q     <= 7'd0;
      key_len_q    <= 7'd0;
      overflow_q   <= 1'b0;
      j_q          <= 7'd0;
      s_q          <= 7'd0;
      byte_ready_q <= 1'b0;
      key_ready_q  <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      key_len_q    <= key_len_d;
      overflow_q   <= overflow_d;
      j_q          <= j_d;
      s_q          <= s_d;
      byte_ready_q <= byte_ready_d;
      key_ready_q  <= key_ready_d;
    end
  end

  // Password and expanded-stream storage, wiped on reset and on every new load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAX_KEY_BYTES; k++) begin
        pw_q[k]  <= 8'h00;
        exp_q[k] <= 8'h00;
      end
    end else if (kb.load_start) begin
      for (int k = 0; k < MAX_KEY_BYTES; k++) begin
        pw_q[k]  <= 8'h00;
        exp_q[k] <= 8'h00;
      end
    end else begin
      if (pw_we_s) begin
        pw_q[wr_cnt_q] <= pw_wdata_s;
      end
      if (exp_we_s) begin
        exp_q[j_q] <= pw_q[s_q];
      end
    end
  end

  // Zero-latency eight-byte read window
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      key_data_s[i] = exp_q[wrap_idx(kb.key_addr, 3'(i))];
    end
  end

  assign kb.key_data   = key_data_s;
  assign kb.byte_ready = byte_ready_q;
  assign kb.key_len    = key_len_q;
  assign kb.key_ready  = key_ready_q;
  assign kb.overflow   = overflow_q;

endmodule : key_buffer
